// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 Set-2 scan-code constants and the decoder FSM state type.
package ps2_pkg;

    localparam int unsigned SC_W   = 8;
    localparam int unsigned CODE_W = 9;

    localparam logic [SC_W-1:0] SC_BREAK  = 8'hF0;
    localparam logic [SC_W-1:0] SC_EXT    = 8'hE0;
    localparam logic [SC_W-1:0] SC_PAUSE  = 8'hE1;
    localparam logic [SC_W-1:0] SC_LSHIFT = 8'h12;
    localparam logic [SC_W-1:0] SC_RSHIFT = 8'h59;
    localparam logic [SC_W-1:0] SC_CTRL   = 8'h14;
    localparam logic [SC_W-1:0] SC_CAPS   = 8'h58;
    localparam logic [SC_W-1:0] SC_SPACE  = 8'h29;
    localparam logic [SC_W-1:0] SC_ENTER  = 8'h5A;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACK    = 2'd1,
        DECODE = 2'd2
    } ps2_state_e;

endpackage

// File: rtl/ps2_ascii_lut.sv
// ps2_ascii_lut: combinational Set-2 scan code to US ASCII translation.
// Ports:
//   code  in  8 : scan code byte
//   ext   in  1 : E0-prefixed key (always maps to 0x00)
//   shift in  1 : Shift held before this event
//   caps  in  1 : Caps Lock state before this event
//   ascii out 8 : ASCII, 0x00 when unmapped
module ps2_ascii_lut
    import ps2_pkg::*;
(
    input  logic [SC_W-1:0] code,
    input  logic            ext,
    input  logic            shift,
    input  logic            caps,
    output logic [7:0]      ascii
);

    logic [7:0] w_lower;
    logic [7:0] w_digit;
    logic [7:0] w_digit_sh;
    logic       w_is_digit;

    // Lowercase letter and digit/shifted-digit tables
    always_comb begin
        w_lower    = 8'h00;
        w_digit    = 8'h00;
        w_digit_sh = 8'h00;
        w_is_digit = 1'b0;
        case (code)
            8'h1C: w_lower = 8'h61;
            8'h32: w_lower = 8'h62;
            8'h21: w_lower = 8'h63;
            8'h23: w_lower = 8'h64;
            8'h24: w_lower = 8'h65;
            8'h2B: w_lower = 8'h66;
            8'h34: w_lower = 8'h67;
            8'h33: w_lower = 8'h68;
            8'h43: w_lower = 8'h69;
            8'h3B: w_lower = 8'h6A;
            8'h42: w_lower = 8'h6B;
            8'h4B: w_lower = 8'h6C;
            8'h3A: w_lower = 8'h6D;
            8'h31: w_lower = 8'h6E;
            8'h44: w_lower = 8'h6F;
            8'h4D: w_lower = 8'h70;
            8'h15: w_lower = 8'h71;
            8'h2D: w_lower = 8'h72;
            8'h1B: w_lower = 8'h73;
            8'h2C: w_lower = 8'h74;
            8'h3C: w_lower = 8'h75;
            8'h2A: w_lower = 8'h76;
            8'h1D: w_lower = 8'h77;
            8'h22: w_lower = 8'h78;
            8'h35: w_lower = 8'h79;
            8'h1A: w_lower = 8'h7A;
            default: w_lower = 8'h00;
        endcase
        case (code)
            8'h45: begin w_is_digit = 1'b1; w_digit = 8'h30; w_digit_sh = 8'h29; end
            8'h16: begin w_is_digit = 1'b1; w_digit = 8'h31; w_digit_sh = 8'h21; end
            8'h1E: begin w_is_digit = 1'b1; w_digit = 8'h32; w_digit_sh = 8'h40; end
            8'h26: begin w_is_digit = 1'b1; w_digit = 8'h33; w_digit_sh = 8'h23; end
            8'h25: begin w_is_digit = 1'b1; w_digit = 8'h34; w_digit_sh = 8'h24; end
            8'h2E: begin w_is_digit = 1'b1; w_digit = 8'h35; w_digit_sh = 8'h25; end
            8'h36: begin w_is_digit = 1'b1; w_digit = 8'h36; w_digit_sh = 8'h5E; end
            8'h3D: begin w_is_digit = 1'b1; w_digit = 8'h37; w_digit_sh = 8'h26; end
            8'h3E: begin w_is_digit = 1'b1; w_digit = 8'h38; w_digit_sh = 8'h2A; end
            8'h46: begin w_is_digit = 1'b1; w_digit = 8'h39; w_digit_sh = 8'h28; end
            default: w_is_digit = 1'b0;
        endcase
    end

    // Letters follow shift^caps; digits follow shift only
    always_comb begin
        ascii = 8'h00;
        if (!ext) begin
            if (w_lower != 8'h00) begin
                ascii = (shift ^ caps) ? (w_lower - 8'h20) : w_lower;
            end else if (w_is_digit) begin
                ascii = shift ? w_digit_sh : w_digit;
            end else if (code == SC_SPACE) begin
                ascii = 8'h20;
            end else if (code == SC_ENTER) begin
                ascii = 8'h0D;
            end
        end
    end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: pops Set-2 bytes from the PS/2 receiver FIFO and emits
// make/break key events with modifier, Caps Lock, ASCII and press-count state.
// Optional feature macro: PS2_TYPEMATIC_FILTER_EN (suppress repeated makes).
// Ports:
//   clk, clrn (async active-low)
//   data[7:0], ready       : upstream FIFO head and non-empty flag
//   nextdata_n             : active-low one-cycle pop strobe
//   key_valid              : one-cycle event pulse
//   key_code[8:0]          : {extended, scan code}
//   key_pressed, key_ascii : make flag and ASCII of the event
//   shift_held, ctrl_held, caps_lock : modifier state
//   key_count[COUNT_W-1:0] : non-modifier make counter (wraps)
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned COUNT_W = 8
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic [SC_W-1:0]    data,
    input  logic               ready,
    output logic               nextdata_n,
    output logic               key_valid,
    output logic [CODE_W-1:0]  key_code,
    output logic               key_pressed,
    output logic [7:0]         key_ascii,
    output logic               shift_held,
    output logic               ctrl_held,
    output logic               caps_lock,
    output logic [COUNT_W-1:0] key_count
);

    ps2_state_e          r_state;
    logic [SC_W-1:0]     r_code;
    logic                r_break_p;
    logic                r_ext_p;
    logic                r_lshift;
    logic                r_rshift;
    logic                r_lctrl;
    logic                r_rctrl;
    logic                r_caps_held;
    logic                r_caps;
    logic                r_nextdata_n;
    logic                r_key_valid;
    logic [CODE_W-1:0]   r_key_code;
    logic                r_key_pressed;
    logic [7:0]          r_key_ascii;
    logic [COUNT_W-1:0]  r_count;

    logic [CODE_W-1:0]   w_code;
    logic                w_make;
    logic                w_is_mod;
    logic                w_suppress;
    logic [7:0]          w_ascii;

    assign w_code   = {r_ext_p, r_code};
    assign w_make   = ~r_break_p;
    assign w_is_mod = (w_code == {1'b0, SC_LSHIFT}) || (w_code == {1'b0, SC_RSHIFT}) ||
                      (w_code == {1'b0, SC_CTRL})   || (w_code == {1'b1, SC_CTRL});

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic [CODE_W-1:0]   r_last_make;
    logic                r_last_valid;

    // A make identical to the last unreleased make is a typematic repeat
    assign w_suppress = w_make && r_last_valid && (r_last_make == w_code);
`else
    assign w_suppress = 1'b0;
`endif

    // ASCII uses modifier state from before the current event
    ps2_ascii_lut u_ascii_lut (
        .code  (r_code),
        .ext   (r_ext_p),
        .shift (r_lshift | r_rshift),
        .caps  (r_caps),
        .ascii (w_ascii)
    );

    // Pop/decode FSM with registered event outputs
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state       <= IDLE;
            r_code        <= '0;
            r_break_p     <= 1'b0;
            r_ext_p       <= 1'b0;
            r_lshift      <= 1'b0;
            r_rshift      <= 1'b0;
            r_lctrl       <= 1'b0;
            r_rctrl       <= 1'b0;
            r_caps_held   <= 1'b0;
            r_caps        <= 1'b0;
            r_nextdata_n  <= 1'b1;
            r_key_valid   <= 1'b0;
            r_key_code    <= '0;
            r_key_pressed <= 1'b0;
            r_key_ascii   <= '0;
            r_count       <= '0;
`ifdef PS2_TYPEMATIC_FILTER_EN
            r_last_make   <= '0;
            r_last_valid  <= 1'b0;
`endif
        end else begin
            r_key_valid  <= 1'b0;
            r_nextdata_n <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (ready) begin
                        r_code       <= data;
                        r_nextdata_n <= 1'b0;
                        r_state      <= ACK;
                    end
                end
                ACK: begin
                    r_state <= DECODE;
                end
                DECODE: begin
                    r_state <= IDLE;
                    case (r_code)
                        SC_BREAK: r_break_p <= 1'b1;
                        SC_EXT:   r_ext_p   <= 1'b1;
                        SC_PAUSE: begin
                            r_break_p <= 1'b0;
                            r_ext_p   <= 1'b0;
                        end
                        default: begin
                            r_break_p <= 1'b0;
                            r_ext_p   <= 1'b0;
                            if (w_code == {1'b0, SC_LSHIFT}) r_lshift <= w_make;
                            if (w_code == {1'b0, SC_RSHIFT}) r_rshift <= w_make;
                            if (w_code == {1'b0, SC_CTRL})   r_lctrl  <= w_make;
                            if (w_code == {1'b1, SC_CTRL})   r_rctrl  <= w_make;
                            // Held bit keeps typematic repeats from re-toggling
                            if (w_code == {1'b0, SC_CAPS}) begin
                                r_caps_held <= w_make;
                                if (w_make && !r_caps_held) r_caps <= ~r_caps;
                            end
`ifdef PS2_TYPEMATIC_FILTER_EN
                            if (w_make) begin
                                r_last_make  <= w_code;
                                r_last_valid <= 1'b1;
                            end else if (r_last_valid && (r_last_make == w_code)) begin
                                r_last_valid <= 1'b0;
                            end
`endif
                            if (!w_suppress) begin
                                r_key_valid   <= 1'b1;
                                r_key_code    <= w_code;
                                r_key_pressed <= w_make;
                                r_key_ascii   <= w_make ? w_ascii : 8'h00;
                                if (w_make && !w_is_mod) r_count <= r_count + COUNT_W'(1);
                            end
                        end
                    endcase
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign nextdata_n  = r_nextdata_n;
    assign key_valid   = r_key_valid;
    assign key_code    = r_key_code;
    assign key_pressed = r_key_pressed;
    assign key_ascii   = r_key_ascii;
    assign shift_held  = r_lshift | r_rshift;
    assign ctrl_held   = r_lctrl | r_rctrl;
    assign caps_lock   = r_caps;
    assign key_count   = r_count;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Bench for ps2_scancode_decoder: FIFO model, event-level reference model and
// per-cycle output comparison, plus literal expectations per scenario.
module tb_ps2_scancode_decoder;

    localparam int unsigned COUNT_W = 8;

    logic               clk = 1'b0;
    logic               clrn = 1'b0;
    logic [7:0]         data = 8'h00;
    logic               ready = 1'b0;
    logic               nextdata_n;
    logic               key_valid;
    logic [8:0]         key_code;
    logic               key_pressed;
    logic [7:0]         key_ascii;
    logic               shift_held;
    logic               ctrl_held;
    logic               caps_lock;
    logic [COUNT_W-1:0] key_count;

    always #5 clk = ~clk;

    ps2_scancode_decoder #(.COUNT_W(COUNT_W)) dut (
        .clk         (clk),
        .clrn        (clrn),
        .data        (data),
        .ready       (ready),
        .nextdata_n  (nextdata_n),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_pressed (key_pressed),
        .key_ascii   (key_ascii),
        .shift_held  (shift_held),
        .ctrl_held   (ctrl_held),
        .caps_lock   (caps_lock),
        .key_count   (key_count)
    );

    typedef struct {
        int                 due;
        logic [8:0]         code;
        logic               pressed;
        logic [7:0]         ascii;
        logic               shift;
        logic               ctrl;
        logic               caps;
        logic [COUNT_W-1:0] count;
    } ev_t;

    typedef struct {
        logic [8:0] code;
        logic       pressed;
        logic [7:0] ascii;
    } obs_t;

    ev_t        exp_q[$];
    ev_t        shown;
    obs_t       obs_log[$];
    logic [7:0] stim_q[$];
    logic [7:0] fifo[$];
    int         n_vec = 0;
    int         n_bad = 0;
    int         cyc = 0;
    logic       prev_nd = 1'b1;

    bit                 m_brk, m_ext, m_caps;
    bit                 m_held [512];
    logic [COUNT_W-1:0] m_count;
`ifdef PS2_TYPEMATIC_FILTER_EN
    logic [8:0]         m_lm;
    bit                 m_lm_v;
`endif

    logic [7:0] letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                   8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                   8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digit_sc  [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] digit_sym [10] = '{8'h29, 8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26, 8'h2A, 8'h28};

    function automatic logic [7:0] ascii_of(logic [8:0] c, bit sh, bit cp);
        if (c[8]) return 8'h00;
        for (int i = 0; i < 26; i++)
            if (c[7:0] == letter_sc[i]) return (sh ^ cp) ? 8'(8'h41 + i) : 8'(8'h61 + i);
        for (int i = 0; i < 10; i++)
            if (c[7:0] == digit_sc[i]) return sh ? digit_sym[i] : 8'(8'h30 + i);
        if (c == 9'h029) return 8'h20;
        if (c == 9'h05A) return 8'h0D;
        return 8'h00;
    endfunction

    function automatic bit is_mod(logic [8:0] c);
        return (c == 9'h012) || (c == 9'h059) || (c == 9'h014) || (c == 9'h114);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, expv);
        end
    endtask

    task automatic model_reset();
        m_brk = 0; m_ext = 0; m_caps = 0; m_count = '0;
        foreach (m_held[i]) m_held[i] = 0;
`ifdef PS2_TYPEMATIC_FILTER_EN
        m_lm = '0; m_lm_v = 0;
`endif
        exp_q.delete();
        shown = '{default: 0};
        prev_nd = 1'b1;
    endtask

    // Reference model: consumes one popped byte, queues the expected event
    task automatic model_byte(logic [7:0] b);
        logic [8:0] c;
        bit         mk, sup, sh;
        ev_t        e;
        if (b == 8'hF0) m_brk = 1;
        else if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hE1) begin m_brk = 0; m_ext = 0; end
        else begin
            c = {m_ext, b};
            mk = !m_brk;
            m_brk = 0; m_ext = 0;
            sh = m_held[9'h012] | m_held[9'h059];
            e.ascii = mk ? ascii_of(c, sh, m_caps) : 8'h00;
            sup = 0;
`ifdef PS2_TYPEMATIC_FILTER_EN
            if (mk) begin
                sup = m_lm_v && (m_lm == c);
                m_lm = c; m_lm_v = 1;
            end else if (m_lm_v && (m_lm == c)) m_lm_v = 0;
`endif
            if (mk && c == 9'h058 && !m_held[c]) m_caps = !m_caps;
            m_held[c] = mk;
            if (!sup) begin
                if (mk && !is_mod(c)) m_count++;
                e.due = cyc + 2;
                e.code = c;
                e.pressed = mk;
                e.shift = m_held[9'h012] | m_held[9'h059];
                e.ctrl = m_held[9'h014] | m_held[9'h114];
                e.caps = m_caps;
                e.count = m_count;
                exp_q.push_back(e);
            end
        end
    endtask

    // Compare process and upstream FIFO model, on the falling edge
    always @(negedge clk) begin
        bit ev_now;
        cyc++;
        if (!clrn) begin
            model_reset();
        end else begin
            ev_now = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            check("key_valid", 32'(key_valid), 32'(ev_now));
            if (ev_now) shown = exp_q.pop_front();
            if (key_valid) obs_log.push_back('{key_code, key_pressed, key_ascii});
            if (ev_now || !key_valid) begin
                check("key_code",    32'(key_code),    32'(shown.code));
                check("key_pressed", 32'(key_pressed), 32'(shown.pressed));
                check("key_ascii",   32'(key_ascii),   32'(shown.ascii));
                check("shift_held",  32'(shift_held),  32'(shown.shift));
                check("ctrl_held",   32'(ctrl_held),   32'(shown.ctrl));
                check("caps_lock",   32'(caps_lock),   32'(shown.caps));
                check("key_count",   32'(key_count),   32'(shown.count));
            end
            if (!nextdata_n) begin
                check("pop_single_cycle", 32'(prev_nd), 32'(1));
                check("pop_nonempty", 32'(fifo.size() != 0), 32'(1));
                if (fifo.size() != 0) model_byte(fifo.pop_front());
            end
            prev_nd = nextdata_n;
        end
        while (stim_q.size() != 0) fifo.push_back(stim_q.pop_front());
        ready = (fifo.size() != 0);
        data  = ready ? fifo[0] : 8'h00;
    end

    task automatic push(logic [7:0] b);
        stim_q.push_back(b);
    endtask

    task automatic settle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clrn = 1'b0;
        settle(2);
        clrn = 1'b1;
        settle(1);
        obs_log.delete();
    endtask

    function automatic obs_t obs_at(int i);
        obs_t bad;
        bad = '{9'h1FF, 1'b1, 8'hFF};
        if (i >= 0 && i < obs_log.size()) return obs_log[i];
        return bad;
    endfunction

    initial begin
        obs_t o;
        bit   found;
        model_reset();
        clrn = 1'b0;
        settle(2);
        check("rst_nextdata_n", 32'(nextdata_n), 32'(1));
        check("rst_key_valid",  32'(key_valid),  32'(0));
        check("rst_key_code",   32'(key_code),   32'(0));
        check("rst_key_count",  32'(key_count),  32'(0));
        check("rst_caps",       32'(caps_lock),  32'(0));
        clrn = 1'b1;
        settle(1);

        // Single make: pop one cycle after ready, event two cycles later
        push(8'h1C);
        settle(1);
        check("t1_pop_low",   32'(nextdata_n), 32'(0));
        settle(1);
        check("t1_pop_high",  32'(nextdata_n), 32'(1));
        check("t1_no_ev_yet", 32'(key_valid),  32'(0));
        settle(1);
        check("t1_valid",   32'(key_valid),   32'(1));
        check("t1_code",    32'(key_code),    32'(9'h01C));
        check("t1_pressed", 32'(key_pressed), 32'(1));
        check("t1_ascii",   32'(key_ascii),   32'(8'h61));
        check("t1_count",   32'(key_count),   32'(1));
        settle(3);

        // Shifted letter, break, shift release
        do_reset();
        push(8'h12); push(8'h1C); push(8'hF0); push(8'h1C); push(8'hF0); push(8'h12);
        settle(25);
        check("t2_events", 32'(obs_log.size()), 32'(4));
        o = obs_at(1); check("t2_upper_a", 32'(o.ascii), 32'(8'h41));
        o = obs_at(2); check("t2_brk_ascii", 32'(o.ascii), 32'(0));
        check("t2_brk_pressed", 32'(o.pressed), 32'(0));
        check("t2_shift_end", 32'(shift_held), 32'(0));
        check("t2_count", 32'(key_count), 32'(1));

        // Caps Lock toggle and typematic protection
        do_reset();
        push(8'h58);
        settle(6);
        check("t3_caps_on", 32'(caps_lock), 32'(1));
        push(8'h58); push(8'hF0); push(8'h58); push(8'h1C);
        settle(16);
        check("t3_caps_repeat", 32'(caps_lock), 32'(1));
        o = obs_at(obs_log.size() - 1); check("t3_caps_A", 32'(o.ascii), 32'(8'h41));
        push(8'h12); push(8'h1C);
        settle(10);
        o = obs_at(obs_log.size() - 1); check("t3_caps_shift_a", 32'(o.ascii), 32'(8'h61));
        check("t3_shift_held", 32'(shift_held), 32'(1));

        // Extended key make/break, ext flag cleared afterwards
        do_reset();
        push(8'hE0); push(8'h75); push(8'hE0); push(8'hF0); push(8'h75); push(8'h1C);
        settle(22);
        check("t4_events", 32'(obs_log.size()), 32'(3));
        o = obs_at(0);
        check("t4_make_code", 32'(o.code), 32'(9'h175));
        check("t4_make_pressed", 32'(o.pressed), 32'(1));
        check("t4_make_ascii", 32'(o.ascii), 32'(0));
        o = obs_at(1);
        check("t4_brk_code", 32'(o.code), 32'(9'h175));
        check("t4_brk_pressed", 32'(o.pressed), 32'(0));
        o = obs_at(2); check("t4_after_code", 32'(o.code), 32'(9'h01C));

        // Repeated makes
        do_reset();
        push(8'h1C); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C);
        settle(20);
`ifdef PS2_TYPEMATIC_FILTER_EN
        check("t5_count", 32'(key_count), 32'(1));
        check("t5_events", 32'(obs_log.size()), 32'(2));
`else
        check("t5_count", 32'(key_count), 32'(3));
        check("t5_events", 32'(obs_log.size()), 32'(4));
`endif

        // Digits, symbols, space, enter, right ctrl
        do_reset();
        push(8'h45); push(8'h12); push(8'h16); push(8'h29); push(8'h5A);
        push(8'hE0); push(8'h14); push(8'hF0); push(8'h12); push(8'h1C);
        settle(40);
        o = obs_at(0); check("t6_digit0", 32'(o.ascii), 32'(8'h30));
        o = obs_at(2); check("t6_bang", 32'(o.ascii), 32'(8'h21));
        o = obs_at(3); check("t6_space", 32'(o.ascii), 32'(8'h20));
        o = obs_at(4); check("t6_enter", 32'(o.ascii), 32'(8'h0D));
        o = obs_at(5); check("t6_rctrl_code", 32'(o.code), 32'(9'h114));
        o = obs_at(7); check("t6_lower_a", 32'(o.ascii), 32'(8'h61));
        check("t6_ctrl_held", 32'(ctrl_held), 32'(1));
        check("t6_shift_held", 32'(shift_held), 32'(0));
        check("t6_count", 32'(key_count), 32'(5));

        // Reset asserted while the pop strobe is low
        do_reset();
        push(8'h12); push(8'h1C);
        settle(12);
        check("t7_pre_count", 32'(key_count), 32'(1));
        push(8'h1C);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            settle(1);
            if (!nextdata_n) found = 1;
        end
        check("t7_saw_ack", 32'(found), 32'(1));
        clrn = 1'b0;
        #1;
        check("t7_nextdata_n", 32'(nextdata_n), 32'(1));
        check("t7_key_valid",  32'(key_valid),  32'(0));
        check("t7_key_code",   32'(key_code),   32'(0));
        check("t7_pressed",    32'(key_pressed), 32'(0));
        check("t7_ascii",      32'(key_ascii),  32'(0));
        check("t7_shift",      32'(shift_held), 32'(0));
        check("t7_ctrl",       32'(ctrl_held),  32'(0));
        check("t7_caps",       32'(caps_lock),  32'(0));
        check("t7_count",      32'(key_count),  32'(0));
        settle(1);
        clrn = 1'b1;
        obs_log.delete();
        settle(10);
        o = obs_at(0);
        check("t7_post_code", 32'(o.code), 32'(9'h01C));
        check("t7_post_ascii", 32'(o.ascii), 32'(8'h61));
        check("t7_post_count", 32'(key_count), 32'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_scancode_decoder.md
# ps2_scancode_decoder

Consumes raw PS/2 Set-2 scan-code bytes from the keyboard receiver FIFO and turns them into discrete key events: make/break, extended-key flag, modifier state, Caps Lock state, ASCII and a press counter. It sits directly downstream of the PS/2 receiver, using its `data`/`ready`/`nextdata_n` read port. It feeds the display/character-buffer logic.

## Interface
- `COUNT_W`, default 8: width of the press counter.
- `clk` in 1: system clock. Everything is on the rising edge.
- `clrn` in 1: reset, asynchronous, active-low.
- `data` in 8: head byte of the upstream FIFO. Valid whenever `ready`=1.
- `ready` in 1: upstream FIFO is non-empty.
- `nextdata_n` out 1: active-low pop strobe to upstream. Low for exactly one cycle per byte consumed.
- `key_valid` out 1: one-cycle pulse; the event outputs below are valid this cycle.
- `key_code` out 9: {extended, scan code}.
- `key_pressed` out 1: 1 for a make event, 0 for a break event.
- `key_ascii` out 8: ASCII of the event. 0x00 for break, extended, modifier or unmapped keys.
- `shift_held` out 1: left (0x12) or right (0x59) Shift is currently down.
- `ctrl_held` out 1: left (0x14) or right (E0 14) Ctrl is currently down.
- `caps_lock` out 1: Caps Lock toggle state.
- `key_count` out COUNT_W: count of emitted make events of non-modifier keys. Wraps modulo 2^COUNT_W.

## Operation
- Reset values:
  - `nextdata_n`=1.
  - All other outputs 0.
  - State IDLE.
  - Both prefix flags cleared.
  - Held-key register cleared.
- The FSM has three states:
  - IDLE: if `ready`=1, latch `data` into `code_r` and go to ACK. Otherwise stay.
  - ACK: `nextdata_n`=0 (decoded from state, glitch-free registered output). Always go to DECODE.
  - DECODE: process `code_r`, then go to IDLE.
- Decoding in DECODE:
  - 0xF0: set `break_p`. No event.
  - 0xE0: set `ext_p`. No event.
  - 0xE1: clear both flags. No event. Pause sequences are ignored byte-wise.
  - Any other byte: emit one event.
    - `key_code`={`ext_p`,byte}.
    - `key_pressed`=~`break_p`.
    - Clear both flags.
  - Repeated prefixes are idempotent: F0 F0 1C is a single break of 0x01C.
- Modifier tracking:
  - Make and break of the Shift/Ctrl codes set and clear per-side held bits.
  - `shift_held` and `ctrl_held` are the OR of their two side bits.
  - Modifier events still pulse `key_valid`.
- Caps Lock:
  - A make of 0x058 toggles `caps_lock` only if 0x058 is not already held.
  - Typematic repeats therefore never re-toggle it.
  - Its break clears the held bit.
- ASCII mapping:
  - Letters: lowercase when `shift_held`^`caps_lock`=0, uppercase otherwise.
  - Digits 0–9 use the US shifted symbols `)!@#$%^&*(` when `shift_held`=1. `caps_lock` does not affect digits.
  - Space 0x29 maps to 0x20 and Enter 0x5A maps to 0x0D.
  - Everything else maps to 0x00.
  - The mapping uses the modifier state from before the current event.
- `key_count` increments on emitted non-modifier make events only.

## Timing
- If a byte is present in IDLE at cycle t:
  - `nextdata_n` is low in cycle t+1.
  - The upstream pop takes effect at the end of t+1.
  - Event outputs are registered at the end of DECODE (cycle t+2) and visible with `key_valid`=1 in cycle t+3.
- `ready` is next sampled in cycle t+3, which is after the upstream pointer has advanced. The stale-`ready` double pop is therefore impossible.
- Throughput is one byte per 3 cycles. Back-to-back bytes give `key_valid` pulses 3 cycles apart.
- Event outputs hold their values between pulses. Only `key_valid` returns to 0.
- `shift_held`, `ctrl_held` and `caps_lock` update in the same cycle as the corresponding `key_valid`.
- If `clrn` is asserted in any state, including ACK, all outputs return to reset values immediately. A byte already popped is lost; this is acceptable.

## Configuration
- `PS2_TYPEMATIC_FILTER_EN`, when defined:
  - The block keeps `last_make` (9 bits) plus a valid bit.
  - A make whose `key_code` equals `last_make` while valid produces no `key_valid` and no count.
  - A break of that code clears valid.
  - A make of a different key replaces `last_make`.
- When undefined, every make byte emits an event and counts.
- In both cases Caps Lock toggling is protected by its held bit.

## Structure
- Shared package `ps2_pkg`:
  - Scan-code constants: `SC_BREAK`, `SC_EXT`, `SC_PAUSE`, `SC_LSHIFT`, `SC_RSHIFT`, `SC_CTRL`, `SC_CAPS`, `SC_SPACE`, `SC_ENTER`.
  - FSM state enum {IDLE, ACK, DECODE}.
- Sub-module `ps2_ascii_lut`: purely combinational. Inputs are `code[7:0]`, `ext`, `shift` and `caps`; output is `ascii[7:0]`. It is instantiated once.

## Test plan
- Queue 1C → one `key_valid`; `key_code`=0x01C, `key_pressed`=1, `key_ascii`=0x61, `key_count`=1. `nextdata_n` is low for exactly one cycle, 1 cycle after `ready`.
- Queue 12,1C,F0,1C,F0,12 → 0x1C make gives `key_ascii`=0x41. Break gives `key_ascii`=0x00 and `key_pressed`=0. `shift_held` ends at 0. `key_count`=1.
- Queue 58,58,F0,58,1C → `caps_lock`=1 after the first 58 and stays 1 after the repeat; 1C gives 0x41. Add Shift held → 0x61.
- Queue E0,75,E0,F0,75 → `key_code`=0x175 make then break, `key_ascii`=0x00. Ext flag is cleared afterwards: a following 1C gives `key_code`=0x01C.
- Queue 1C,1C,1C,F0,1C → with the macro: one make and one break, `key_count`=1. Without: three makes, `key_count`=3.
- Assert `clrn` during ACK → `nextdata_n`=1 and all outputs 0 in the same cycle. After release, the next queued byte decodes normally.
